serializer_frame_ctrl: RTL and testbench
========================================

SERIALIZER_FRAME_CTRL -- requirements
Module: serializer_frame_ctrl

Interface
REQ-001 Parameter WORDWIDTH, default 8, SHALL set the serializer word width and the bit-counter period.
REQ-002 Parameter SYNC_WORD, default 8'h3C (WORDWIDTH bits), SHALL be the pattern loaded during the sync preamble.
REQ-003 Parameter IDLE_WORD, default 8'hAA (WORDWIDTH bits), SHALL be the filler loaded when no data word is available.
REQ-004 Parameter SYNC_COUNT, default 4, range 1..255, SHALL set the number of sync words per preamble.
REQ-005 Port bitCK, input, 1: the single clock, the same bit clock as the serializer; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port enable, input, 1: global clock enable; it is passed unchanged to serEnable.
REQ-008 Port start, input, 1: request to begin a frame stream; it is sampled in IDLE only.
REQ-009 Port stop, input, 1: level request to end the stream; it is sampled on load cycles in SYNC or RUN.
REQ-010 Port wordValid, input, 1: upstream data word available.
REQ-011 Port wordData, input, WORDWIDTH: upstream data word.
REQ-012 Port wordReady, output, 1: the data word is consumed on this edge when wordValid=1.
REQ-013 Port serEnable, output, 1: serializer enable, equal to enable.
REQ-014 Port serLoad, output, 1: serializer load strobe.
REQ-015 Port serDin, output, WORDWIDTH: serializer parallel word.
REQ-016 Port busy, output, 1: high whenever state is not IDLE.
REQ-017 Port dataCount, output, 16: count of accepted data words.
REQ-018 Port idleCount, output, 16: count of inserted IDLE_WORDs.

Function
REQ-019 The FSM SHALL have states IDLE, SYNC and RUN, plus a bit counter cnt (0..WORDWIDTH-1) and a sync counter syncCnt (8 bits).
REQ-020 When enable=0, all registers SHALL hold their values, and serLoad and wordReady SHALL be 0.
REQ-021 In IDLE with enable=1 and start=1, the next state SHALL be SYNC, with cnt=0 and syncCnt=0.
REQ-022 In SYNC and RUN with enable=1, cnt SHALL increment each cycle and wrap from WORDWIDTH-1 to 0.
REQ-023 serLoad SHALL be combinational and equal enable AND (state!=IDLE) AND (cnt==WORDWIDTH-1); it is therefore asserted once every WORDWIDTH cycles.
REQ-024 The first serLoad after leaving IDLE SHALL occur WORDWIDTH cycles after the start edge.
REQ-025 In SYNC, serDin SHALL be SYNC_WORD; each serLoad SHALL increment syncCnt.
REQ-026 The SYNC-to-RUN transition SHALL happen on the serLoad for which syncCnt==SYNC_COUNT-1, so exactly SYNC_COUNT sync words are loaded.
REQ-027 In RUN, wordReady SHALL equal serLoad AND NOT stop.
REQ-028 In RUN, serDin SHALL be wordData when wordReady AND wordValid; otherwise it SHALL be IDLE_WORD.
REQ-029 In IDLE, serDin SHALL be IDLE_WORD.
REQ-030 A serLoad cycle with wordReady=1 and wordValid=1 SHALL increment dataCount, which wraps modulo 2^16.
REQ-031 A serLoad cycle in RUN that loads IDLE_WORD SHALL increment idleCount, which saturates at 16'hFFFF.
REQ-032 On a serLoad cycle in SYNC or RUN with stop=1, the current word SHALL still be loaded, and the next state SHALL be IDLE with cnt=0.
REQ-033 If stop=1 on the final sync load, stop SHALL take priority and the next state SHALL be IDLE.
REQ-034 start while busy=1 SHALL be ignored, and stop while in IDLE SHALL be ignored.
REQ-035 wordData SHALL be consumed only on cycles with wordReady=1; otherwise there SHALL be no upstream side effects.

Reset
REQ-036 reset=1 at a rising edge of bitCK SHALL force state=IDLE, cnt=0, syncCnt=0, dataCount=0 and idleCount=0, regardless of enable.
REQ-037 After reset, busy=0, serLoad=0, wordReady=0 and serDin=IDLE_WORD.
REQ-038 A reset asserted mid-word or mid-preamble SHALL abort immediately with no further serLoad.

Verification (WORDWIDTH=8, SYNC_COUNT=4)
REQ-039 Start pulse with enable=1 -> serLoad at cycles 8, 16, 24 and 32 with serDin=8'h3C; RUN is entered after cycle 32.
REQ-040 RUN with wordValid held at 1 and wordData incrementing -> one word is accepted every 8 cycles, dataCount increments, idleCount=0.
REQ-041 RUN with wordValid=0 for 3 loads -> serDin=8'hAA on those loads, idleCount=3, wordReady pulses not consumed.
REQ-042 stop raised mid-word in RUN -> that word's load carries IDLE_WORD with wordReady=0, busy falls on the next edge, and no serLoad follows.
REQ-043 enable=0 for 5 cycles mid-word -> cnt is frozen and the load period is stretched to 13 cycles; serEnable=0 throughout.
REQ-044 reset during SYNC at syncCnt=2 -> IDLE on the next edge, counters cleared, and a new start replays the full 4-word preamble.

Source files
------------

// File: rtl/serializer_frame_ctrl.sv
// rtl/serializer_frame_ctrl.sv - frame controller feeding a parallel-load serializer: sync preamble then data/idle words
module serializer_frame_ctrl #(
    parameter int                   WORDWIDTH  = 8,
    parameter logic [WORDWIDTH-1:0] SYNC_WORD  = WORDWIDTH'(8'h3C),
    parameter logic [WORDWIDTH-1:0] IDLE_WORD  = WORDWIDTH'(8'hAA),
    parameter int                   SYNC_COUNT = 4
) (
    input  logic                 bitCK,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 wordValid,
    input  logic [WORDWIDTH-1:0] wordData,
    output logic                 wordReady,
    output logic                 serEnable,
    output logic                 serLoad,
    output logic [WORDWIDTH-1:0] serDin,
    output logic                 busy,
    output logic [15:0]          dataCount,
    output logic [15:0]          idleCount
);

    localparam int             CW        = (WORDWIDTH > 1) ? $clog2(WORDWIDTH) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(WORDWIDTH - 1);
    localparam logic [7:0]     SYNC_LAST = 8'(SYNC_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    sync_cnt;
    logic          cnt_last;
    logic          word_take;

    assign cnt_last  = (cnt == CNT_MAX);
    assign serEnable = enable;
    assign busy      = (state != IDLE);
    assign serLoad   = enable && (state != IDLE) && cnt_last;
    assign wordReady = serLoad && (state == RUN) && !stop;
    assign word_take = wordReady && wordValid;

    always_comb begin
        serDin = IDLE_WORD;
        if (state == SYNC)
            serDin = SYNC_WORD;
        else if (state == RUN && word_take)
            serDin = wordData;
    end

    always_ff @(posedge bitCK) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sync_cnt  <= '0;
            dataCount <= '0;
            idleCount <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SYNC;
                        cnt      <= '0;
                        sync_cnt <= '0;
                    end
                end
                SYNC: begin
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                    if (cnt_last) begin
                        // stop wins over the final-sync-word transition
                        if (stop) begin
                            state <= IDLE;
                        end else begin
                            sync_cnt <= sync_cnt + 8'd1;
                            if (sync_cnt == SYNC_LAST)
                                state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                    if (cnt_last && stop)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (serLoad && word_take)
                dataCount <= dataCount + 16'd1;
            // filler loads in RUN, including the final load that carries stop
            if (serLoad && state == RUN && !word_take && idleCount != 16'hFFFF)
                idleCount <= idleCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_serializer_frame_ctrl.sv
// tb/tb_serializer_frame_ctrl.sv - directed self-checking bench for serializer_frame_ctrl
module tb_serializer_frame_ctrl;

    logic        bitCK = 1'b0;
    logic        reset, enable, start, stop, wordValid;
    logic [7:0]  wordData;
    logic        wordReady, serEnable, serLoad, busy;
    logic [7:0]  serDin;
    logic [15:0] dataCount, idleCount;

    int checks   = 0;
    int failures = 0;

    serializer_frame_ctrl dut (
        .bitCK     (bitCK),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .stop      (stop),
        .wordValid (wordValid),
        .wordData  (wordData),
        .wordReady (wordReady),
        .serEnable (serEnable),
        .serLoad   (serLoad),
        .serDin    (serDin),
        .busy      (busy),
        .dataCount (dataCount),
        .idleCount (idleCount)
    );

    always #5 bitCK = ~bitCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge bitCK);
        #1;
    endtask

    // start edge, then 32 edges of preamble; optional stop raised before edge stop_at
    task automatic preamble(input int stop_at);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k == stop_at) stop = 1'b1;
            check("sync_load", serLoad, (k % 8) == 0);
            check("sync_ready", wordReady, 1'b0);
            if ((k % 8) == 0) check("sync_din", serDin, 8'h3C);
            step();
        end
        check("preamble_busy", busy, stop_at == 0);
        stop = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] d;
        reset = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
        wordValid = 1'b0; wordData = 8'h00;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_load", serLoad, 1'b0);
        check("rst_ready", wordReady, 1'b0);
        check("rst_din", serDin, 8'hAA);
        check("rst_dcnt", dataCount, 16'd0);
        check("rst_icnt", idleCount, 16'd0);
        check("rst_ser_en", serEnable, 1'b1);

        // stop in IDLE has no effect
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("idle_stop_busy", busy, 1'b0);

        preamble(0);

        // RUN, data always valid, incrementing
        wordValid = 1'b1;
        d = 8'h10;
        wordData = d;
        for (int k = 1; k <= 24; k++) begin
            check("run_load", serLoad, (k % 8) == 0);
            if ((k % 8) == 0) begin
                check("run_ready", wordReady, 1'b1);
                check("run_din", serDin, d);
            end
            step();
            if ((k % 8) == 0) begin
                d = d + 8'd1;
                wordData = d;
            end
        end
        check("run_dcnt", dataCount, 16'd3);
        check("run_icnt", idleCount, 16'd0);

        // RUN with no upstream data
        wordValid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if ((k % 8) == 0) begin
                check("fill_ready", wordReady, 1'b1);
                check("fill_din", serDin, 8'hAA);
            end
            step();
        end
        check("fill_icnt", idleCount, 16'd3);
        check("fill_dcnt", dataCount, 16'd3);

        // enable low for 5 cycles mid-word stretches the period to 13
        wordValid = 1'b1;
        wordData = 8'h55;
        n = 0;
        for (int k = 0; k < 3; k++) begin step(); n++; end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("hold_ser_en", serEnable, 1'b0);
            check("hold_load", serLoad, 1'b0);
            check("hold_ready", wordReady, 1'b0);
            step(); n++;
        end
        enable = 1'b1;
        while (!serLoad && n < 40) begin step(); n++; end
        check("stretch_period", n + 1, 13);
        check("stretch_din", serDin, 8'h55);
        step();
        check("stretch_dcnt", dataCount, 16'd4);

        // stop mid-word: last load carries filler, then IDLE
        for (int k = 0; k < 3; k++) step();
        stop = 1'b1;
        n = 0;
        while (!serLoad && n < 20) begin step(); n++; end
        check("stop_found_load", serLoad, 1'b1);
        check("stop_ready", wordReady, 1'b0);
        check("stop_din", serDin, 8'hAA);
        step();
        stop = 1'b0;
        check("stop_busy", busy, 1'b0);
        check("stop_icnt", idleCount, 16'd4);
        check("stop_dcnt", dataCount, 16'd4);
        n = 0;
        for (int k = 0; k < 16; k++) begin
            if (serLoad) n++;
            step();
        end
        check("stop_no_loads", n, 0);
        wordValid = 1'b0;

        // reset mid-preamble after two sync loads
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 19; k++) step();
        check("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_load", serLoad, 1'b0);
        check("mid_rst_dcnt", dataCount, 16'd0);
        check("mid_rst_icnt", idleCount, 16'd0);
        preamble(0);

        // back to IDLE, then a preamble with stop on the final sync load
        stop = 1'b1;
        n = 0;
        while (!serLoad && n < 20) begin step(); n++; end
        step();
        stop = 1'b0;
        check("run_stop_busy", busy, 1'b0);
        preamble(30);
        check("final_sync_stop_icnt", idleCount, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
